// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if: main-bus side of the UART TX endpoint.
// The CPU (master) writes bytes and reads the status byte. The endpoint
// (slave) drives the status byte and its output enable.
interface io_uart_tx_if;
    logic [7:0] data_in;
    logic       load;
    logic       status_oe;
    logic [7:0] bus_out;
    logic       bus_oe;

    modport master (
        output data_in,
        output load,
        output status_oe,
        input  bus_out,
        input  bus_oe
    );

    modport slave (
        input  data_in,
        input  load,
        input  status_oe,
        output bus_out,
        output bus_oe
    );
endinterface

// File: rtl/io_uart_tx.sv
// io_uart_tx: CPU output-port endpoint. Bytes written over the main bus are
// buffered in a small FIFO and sent 8N1, LSB first, on the tx line.
// A status byte can be read back so software can poll for FIFO space.
//
// Optional feature macro: IO_UART_PARITY_EN
//   defined   -> an even-parity bit follows the data bits (11-bit frames),
//                status bit4 reads 1
//   undefined -> plain 8N1 (10-bit frames), status bit4 reads 0
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit, 2..255
//   FIFO_DEPTH    FIFO entries, power of 2, 2..16
//
// Status byte: {3'b000, parity_en, overrun, tx_busy, empty, fifo_full}
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line held high, waiting for a byte in the FIFO
// START  | start bit (0) for CLKS_PER_BIT cycles
// DATA   | eight data bits, LSB first, shift register moves right
// PARITY | even parity over the data bits (IO_UART_PARITY_EN only)
// STOP   | stop bit (1); pops the next byte directly if one is waiting
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rstn,
    io_uart_tx_if.slave    bus,
    output logic           tx,
    output logic           fifo_full,
    output logic           tx_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BAUD_W = 8;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef IO_UART_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    localparam logic PARITY_FLAG = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             fifo_full_d;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             overflow;

    // Sticky overrun flag
    logic             overrun_q;
    logic             overrun_d;

    // Serialiser
    state_t           state_q;
    state_t           state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic             baud_tc;
    logic [2:0]       bit_q;
    logic [2:0]       bit_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             tx_d;
    logic             tx_busy_d;
`ifdef IO_UART_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    logic [7:0]       status;

    // Fullness is judged on the registered (pre-edge) flag, so a write that
    // coincides with a pop from a full FIFO is still rejected.
    assign push       = bus.load && !fifo_full;
    assign overflow   = bus.load && fifo_full;
    assign fifo_empty = (count_q == '0);
    assign baud_tc    = (baud_q == BAUD_LAST);

    // Occupancy after this edge's push and pop
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        fifo_full_d = (count_d == CNT_FULL);
    end

    // Overrun is set by a dropped write and cleared by a status read; a drop
    // in the same edge as the read keeps it set.
    always_comb begin
        overrun_d = overrun_q;
        if (overflow) begin
            overrun_d = 1'b1;
        end else if (bus.status_oe) begin
            overrun_d = 1'b0;
        end
    end

    // FIFO data array; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    // FIFO pointers, occupancy, full flag and overrun flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fifo_full <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q   <= count_d;
            fifo_full <= fifo_full_d;
            overrun_q <= overrun_d;
        end
    end

    // Serialiser next state: bit timing, shifting and the registered tx value
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx;
        pop     = 1'b0;
`ifdef IO_UART_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end

            S_START: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_DATA: begin
                if (baud_tc) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef IO_UART_PARITY_EN
                        tx_d    = parity_q;
                        state_d = S_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

`ifdef IO_UART_PARITY_EN
            S_PARITY: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif

            S_STOP: begin
                if (baud_tc) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        // Both IDLE and end-of-STOP launch a frame the same way, which is what
        // makes queued frames run back to back with no idle cycle.
        if (pop) begin
            shift_d = mem[rd_ptr_q];
            baud_d  = '0;
            bit_d   = 3'd0;
            tx_d    = 1'b0;
            state_d = S_START;
`ifdef IO_UART_PARITY_EN
            parity_d = ^mem[rd_ptr_q];
`endif
        end

        tx_busy_d = (state_d != S_IDLE);
    end

    // Serialiser state register; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
`ifdef IO_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            tx_busy <= tx_busy_d;
`ifdef IO_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign status      = {3'b000, PARITY_FLAG, overrun_q, tx_busy, fifo_empty, fifo_full};
    assign bus.bus_out = bus.status_oe ? status : 8'h00;
    assign bus.bus_oe  = bus.status_oe;

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
- Peripheral-side endpoint for the CPU's output port. It receives bytes the CPU writes from the main bus, buffers them in a small FIFO, and serialises them 8N1 on a single UART TX line.
- Also presents a status byte the CPU can read back over the main bus, so programs can poll for space before writing.
- Sits beside io_block and is controlled by its decoded load/out strobes.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..255
FIFO_DEPTH, 4, FIFO entries; must be a power of 2, legal range 2..16

Ports:
clk  input  1  system clock; all state changes on rising edge
rstn  input  1  synchronous active-low reset
data_in  input  8  byte from main bus
load  input  1  write strobe; data_in is captured at the clk edge while high
status_oe  input  1  status read strobe; drives bus_out and asserts bus_oe
bus_out  output  8  status byte; 8'h00 when status_oe=0
bus_oe  output  1  equals status_oe; top level uses it to tri-state main bus
tx  output  1  serial line; idle high
fifo_full  output  1  FIFO holds FIFO_DEPTH bytes
tx_busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Reset (rstn=0 at a rising edge): FIFO count=0; rd/wr pointers=0; overrun=0; state=IDLE; tx=1; tx_busy=0; fifo_full=0; baud counter=0; bit index=0.
  - Reset mid-frame aborts the frame; tx is 1 after that same edge.
  - All buffered bytes are discarded.
- FIFO write:
  - At an edge with load=1 and fifo_full=0, data_in is stored and count increments.
  - At an edge with load=1 and fifo_full=1, the byte is dropped and overrun is set (sticky).
  - Fullness is judged on pre-edge count. A write in the same edge as a pop is rejected if the FIFO was full before that edge.
  - Pointers wrap modulo FIFO_DEPTH.
- Status byte, combinational from registered state:
  - bit0 = fifo_full
  - bit1 = empty (count==0)
  - bit2 = tx_busy
  - bit3 = overrun
  - bits7:4 = 0
- Overrun clear:
  - An edge with status_oe=1 clears overrun.
  - If load overflows in that same edge, overrun stays set (set wins).
- TX state machine: IDLE, START, DATA, STOP.
  - IDLE: tx=1. At an edge with count>0:
    - pop the head byte into shift register;
    - baud counter=0, state=START, tx=0.
    - Latency: a write at edge N into an empty idle FIFO gives tx=0 after edge N+1.
  - Each bit lasts exactly CLKS_PER_BIT cycles. The counter advances 0..CLKS_PER_BIT-1; on the terminal count it resets to 0 and moves to the next bit.
  - START -> DATA: tx = shift[0]; bit index=0.
  - DATA: bits are sent LSB first; shift right on each bit boundary. After bit 7 completes -> STOP, tx=1.
  - STOP, at terminal count:
    - if count>0, pop and go directly to START (tx=0), giving back-to-back frames with no extra idle cycle;
    - otherwise go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles from falling start edge to the next possible start.
- tx, fifo_full and tx_busy are registered outputs.
- load and pop in the same edge when count>0 and not full: both take effect; count is unchanged.

Optional Feature:
IO_UART_PARITY_EN
- Defined:
  - adds state PARITY between DATA and STOP, transmitting even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles;
  - frame becomes 11*CLKS_PER_BIT cycles;
  - status bit4 reads 1 to advertise parity.
- Undefined: no PARITY state, 10-bit frames, status bit4 = 0.

Test Plan:
- Reset release, no load, CLKS_PER_BIT=4 -> tx=1, tx_busy=0, status=8'h02 for 50 cycles.
- Write 8'hA5 at edge N -> tx=0 after edge N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop=1. tx_busy falls 40 cycles after edge N+1.
- Write 8'h01,8'h02,8'h03 on consecutive edges -> three frames back-to-back: total 120 cycles of busy, no idle cycle between stop and next start, decoded bytes in order 01,02,03.
- FIFO_DEPTH=4: six writes on consecutive edges during the first frame -> fifo_full=1 while full, the 6th byte dropped, status bit3=1. The status_oe edge clears bit3. Only five bytes appear on tx.
- Assert rstn=0 for one edge in the middle of DATA bit 3 with 2 bytes queued -> tx=1 immediately after that edge, status=8'h02, no further frames.
- With IO_UART_PARITY_EN, write 8'h07 -> parity bit=1 after data, frame 44 cycles, status bit4=1.
